// File: rtl/async_fifo_pkg.sv
// ============================================================================
// Module   : async_fifo_pkg
// Brief    : Shared defaults and pointer type for the async_fifo slice.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package async_fifo_pkg;

  localparam int c_DATA_WIDTH = 8;
  localparam int c_ADDR_WIDTH = 4;
  localparam int c_DEPTH      = 1 << c_ADDR_WIDTH;

  // Address bits plus one wrap bit, so full and empty can be told apart.
  typedef logic [c_ADDR_WIDTH:0] ptr_t;

endpackage : async_fifo_pkg

`default_nettype wire

// File: rtl/async_fifo_mem.sv
// ============================================================================
// Module   : async_fifo_mem
// Brief    : DEPTH x DATA_WIDTH simple dual-port RAM, synchronous write and
//            registered read; the storage array itself has no reset.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module async_fifo_mem
  import async_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = c_DATA_WIDTH,
  parameter int ADDR_WIDTH = c_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_wr_en,
  input  logic [ADDR_WIDTH-1:0] i_wr_addr,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  input  logic                  i_rd_en,
  input  logic [ADDR_WIDTH-1:0] i_rd_addr,
  output logic [DATA_WIDTH-1:0] o_rd_data
);

  localparam int c_MEM_DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] r_mem [c_MEM_DEPTH];
  logic [DATA_WIDTH-1:0] r_rd_data;

  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  // Output register holds its value whenever no read is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_data <= '0;
    end else if (i_rd_en) begin
      r_rd_data <= r_mem[i_rd_addr];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule : async_fifo_mem

`default_nettype wire

// File: rtl/async_fifo.sv
// ============================================================================
// Module   : async_fifo
// Brief    : Single-clock FIFO with wrap-bit pointers and combinational flags.
//            Define ASYNC_FIFO_COUNT_EN to add the fifo_count occupancy port.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module async_fifo
  import async_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = c_DATA_WIDTH,
  parameter int ADDR_WIDTH = c_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  fifo_Full,
  output logic                  fifo_Empty
`ifdef ASYNC_FIFO_COUNT_EN
  ,
  output logic [ADDR_WIDTH:0]   fifo_count
`endif
);

  // Pointer type comes from the package; ADDR_WIDTH is expected to match it.
  ptr_t r_wr_ptr;
  ptr_t r_rd_ptr;
  logic w_full;
  logic w_empty;
  logic w_wr_acc;
  logic w_rd_acc;

  assign w_empty  = (r_wr_ptr == r_rd_ptr);
  assign w_full   = (r_wr_ptr[ADDR_WIDTH-1:0] == r_rd_ptr[ADDR_WIDTH-1:0]) &&
                    (r_wr_ptr[ADDR_WIDTH] != r_rd_ptr[ADDR_WIDTH]);
  assign w_wr_acc = wr_en && !w_full;
  assign w_rd_acc = rd_en && !w_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr_acc) begin
        r_wr_ptr <= r_wr_ptr + ptr_t'(1);
      end
      if (w_rd_acc) begin
        r_rd_ptr <= r_rd_ptr + ptr_t'(1);
      end
    end
  end

  async_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_wr_en   (w_wr_acc),
    .i_wr_addr (r_wr_ptr[ADDR_WIDTH-1:0]),
    .i_wr_data (wr_data),
    .i_rd_en   (w_rd_acc),
    .i_rd_addr (r_rd_ptr[ADDR_WIDTH-1:0]),
    .o_rd_data (rd_data)
  );

  assign fifo_Full  = w_full;
  assign fifo_Empty = w_empty;

`ifdef ASYNC_FIFO_COUNT_EN
  // Modular difference of the wrap-bit pointers spans 0..DEPTH.
  assign fifo_count = r_wr_ptr - r_rd_ptr;
`endif

endmodule : async_fifo

`default_nettype wire

// File: tb/tb_async_fifo.sv
// ============================================================================
// Module   : tb_async_fifo
// Brief    : Directed self-checking bench for async_fifo (default build).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_async_fifo;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       fifo_Full;
  logic       fifo_Empty;
`ifdef ASYNC_FIFO_COUNT_EN
  logic [4:0] fifo_count;
`endif

  int checks = 0;
  int passed = 0;
  logic [7:0] q[$];
  logic [7:0] exp_v;

  async_fifo dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .rd_en      (rd_en),
    .rd_data    (rd_data),
    .fifo_Full  (fifo_Full),
    .fifo_Empty (fifo_Empty)
`ifdef ASYNC_FIFO_COUNT_EN
    ,
    .fifo_count (fifo_count)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n   = 1'b0;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    wr_data = 8'h00;
    #1;
    check("reset_empty", fifo_Empty, 1);
    check("reset_full", fifo_Full, 0);
    check("reset_rd_data", rd_data, 0);
    step();
    step();
    rst_n = 1'b1;

    // Fill with 0x01..0x10
    for (int i = 1; i <= 16; i++) begin
      wr_en   = 1'b1;
      wr_data = 8'(i);
      step();
      if (i == 1)  check("fill_not_empty", fifo_Empty, 0);
      if (i == 15) check("fill15_not_full", fifo_Full, 0);
    end
    check("fill16_full", fifo_Full, 1);
    wr_data = 8'hFF;
    step();
    check("overflow_still_full", fifo_Full, 1);
    wr_en = 1'b0;

    // Drain, expecting 0x01..0x10 (the 0xFF write must be gone)
    rd_en = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      step();
      check("drain_data", rd_data, 32'(i));
      if (i == 1)  check("drain_not_full", fifo_Full, 0);
      if (i == 15) check("drain15_not_empty", fifo_Empty, 0);
    end
    check("drain_empty", fifo_Empty, 1);

    // Underflow: three reads while empty
    for (int i = 0; i < 3; i++) begin
      step();
      check("underflow_hold", rd_data, 32'h10);
      check("underflow_empty", fifo_Empty, 1);
    end

    // Read while empty plus write: write lands, read ignored
    wr_en   = 1'b1;
    wr_data = 8'h5A;
    step();
    check("empty_rw_hold", rd_data, 32'h10);
    check("empty_rw_not_empty", fifo_Empty, 0);
    wr_en = 1'b0;
    step();
    check("empty_rw_readback", rd_data, 32'h5A);
    check("empty_rw_empty", fifo_Empty, 1);
    rd_en = 1'b0;

    // Concurrency: 8 stored, then 20 cycles of simultaneous write+read
    wr_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      wr_data = 8'h20 + 8'(i);
      q.push_back(wr_data);
      step();
    end
    rd_en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      wr_data = 8'h40 + 8'(i * 7);
      q.push_back(wr_data);
      exp_v = q.pop_front();
      step();
      check("conc_data", rd_data, 32'(exp_v));
      check("conc_flags", {30'd0, fifo_Full, fifo_Empty}, 0);
    end
    wr_en = 1'b0;
    for (int i = 0; i < 8; i++) begin
      exp_v = q.pop_front();
      step();
      check("conc_drain", rd_data, 32'(exp_v));
    end
    check("conc_drain_empty", fifo_Empty, 1);
    rd_en = 1'b0;

    // Full with simultaneous write+read
    wr_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      wr_data = 8'h80 + 8'(i);
      step();
    end
    check("full2", fifo_Full, 1);
    wr_data = 8'hEE;
    rd_en   = 1'b1;
    step();
    check("full_rw_data", rd_data, 32'h80);
    check("full_rw_not_full", fifo_Full, 0);
    wr_en = 1'b0;
    for (int i = 1; i < 16; i++) begin
      step();
      check("full_rw_drain", rd_data, 32'h80 + 32'(i));
    end
    check("full_rw_empty", fifo_Empty, 1);
    rd_en = 1'b0;

    // Reset mid-traffic
    wr_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wr_data = 8'h60 + 8'(i);
      step();
    end
    #3;
    rst_n = 1'b0;
    #1;
    check("midrst_empty", fifo_Empty, 1);
    check("midrst_full", fifo_Full, 0);
    check("midrst_rd_data", rd_data, 0);
    wr_en = 1'b0;
    step();
    rst_n = 1'b1;
    rd_en = 1'b1;
    step();
    check("post_rst_read_ignored", rd_data, 0);
    check("post_rst_empty", fifo_Empty, 1);
    rd_en   = 1'b0;
    wr_en   = 1'b1;
    wr_data = 8'h77;
    step();
    check("post_rst_write", fifo_Empty, 0);
    wr_en = 1'b0;
    rd_en = 1'b1;
    step();
    check("post_rst_readback", rd_data, 32'h77);
    check("post_rst_final_empty", fifo_Empty, 1);
    rd_en = 1'b0;
    step();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule : tb_async_fifo

`default_nettype wire
